// File: rtl/shifter_pipe.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with carry-out and valid/ready handshake on both sides.
// Optional feature macro: SHIFTER_REGMODE_EN enables register-shift semantics (in_regmode).
module shifter_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AMTW   = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAGW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [AMTW-1:0]   in_amt,
    input  logic [1:0]        in_code,
    input  logic              in_regmode,
    input  logic              in_cflag,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry,
    output logic [TAGW-1:0]   out_tag
);

    localparam int unsigned LVLS = $clog2(WIDTH);
    // Working vector {fill, data, carry_in}; every op becomes a right shift of it.
    localparam int unsigned VW   = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        OP_LSL = 2'd0,
        OP_LSR = 2'd1,
        OP_ASR = 2'd2,
        OP_ROR = 2'd3
    } op_e;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < int'(WIDTH); k++) begin
            r[k] = x[int'(WIDTH) - 1 - k];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] dec_fill;
    logic [WIDTH-1:0] dec_din;
    logic [WIDTH-1:0] sgn_fill;
    logic             dec_cin;
    logic             dec_rev;
    logic [LVLS-1:0]  dec_amt;

`ifdef SHIFTER_REGMODE_EN
    logic amt_zero;
    logic amt_eq;
    logic amt_gt;

    assign amt_zero = (in_amt == '0);
    assign amt_eq   = (in_amt == AMTW'(WIDTH));
    assign amt_gt   = (in_amt >  AMTW'(WIDTH));
`else
    logic unused_inputs;

    assign unused_inputs = ^{in_regmode, in_amt[AMTW-1:LVLS]};
`endif

    // Map each op onto a right shift of {fill, din, cin} by dec_amt; LSL runs bit-reversed.
    always_comb begin
        sgn_fill = {WIDTH{in_data[WIDTH-1]}};
        dec_fill = '0;
        dec_din  = in_data;
        dec_cin  = in_cflag;
        dec_rev  = 1'b0;
        dec_amt  = in_amt[LVLS-1:0];
`ifdef SHIFTER_REGMODE_EN
        if (in_regmode) begin
            case (op_e'(in_code))
                OP_LSL: begin
                    dec_rev = 1'b1;
                    dec_din = bitrev(in_data);
                    if (amt_eq) begin
                        dec_din = '0;
                        dec_cin = in_data[0];
                        dec_amt = '0;
                    end else if (amt_gt) begin
                        dec_din = '0;
                        dec_cin = 1'b0;
                        dec_amt = '0;
                    end
                end
                OP_LSR: begin
                    if (amt_eq) begin
                        dec_din = '0;
                        dec_cin = in_data[WIDTH-1];
                        dec_amt = '0;
                    end else if (amt_gt) begin
                        dec_din = '0;
                        dec_cin = 1'b0;
                        dec_amt = '0;
                    end
                end
                OP_ASR: begin
                    dec_fill = sgn_fill;
                    if (amt_eq || amt_gt) begin
                        dec_din = sgn_fill;
                        dec_cin = in_data[WIDTH-1];
                        dec_amt = '0;
                    end
                end
                default: begin
                    dec_fill = in_data;
                    if (!amt_zero && (dec_amt == '0)) begin
                        dec_cin = in_data[WIDTH-1];
                    end
                end
            endcase
        end else begin
`endif
            case (op_e'(in_code))
                OP_LSL: begin
                    dec_rev = 1'b1;
                    dec_din = bitrev(in_data);
                end
                OP_LSR: begin
                    if (dec_amt == '0) begin
                        dec_din = '0;
                        dec_cin = in_data[WIDTH-1];
                    end
                end
                OP_ASR: begin
                    dec_fill = sgn_fill;
                    if (dec_amt == '0) begin
                        dec_din = sgn_fill;
                        dec_cin = in_data[WIDTH-1];
                    end
                end
                default: begin
                    dec_fill = in_data;
                    // RRX: a one-bit rotate with the C flag entering at the top
                    if (dec_amt == '0) begin
                        dec_fill[0] = in_cflag;
                        dec_amt     = LVLS'(1);
                    end
                end
            endcase
`ifdef SHIFTER_REGMODE_EN
        end
`endif
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] rdy;
    logic              bub;
    logic [VW-1:0]     v_in  [STAGES];
    logic [VW-1:0]     v_sh  [STAGES];
    logic [VW-1:0]     v_q   [STAGES];
    logic [LVLS-1:0]   s_in  [STAGES];
    logic [LVLS-1:0]   s_q   [STAGES];
    logic              rev_in[STAGES];
    logic              rev_q [STAGES];
    logic [TAGW-1:0]   tag_in[STAGES];
    logic [TAGW-1:0]   tag_q [STAGES];
    logic [WIDTH-1:0]  data_q;
    logic              carry_q;

    assign vld_in = STAGES'({vld_q, in_valid});

    // Stage inputs: decode feeds stage 0, each later stage reads its predecessor.
    always_comb begin
        v_in[0]   = {dec_fill, dec_din, dec_cin};
        s_in[0]   = dec_amt;
        rev_in[0] = dec_rev;
        tag_in[0] = in_tag;
        for (int i = 1; i < int'(STAGES); i++) begin
            v_in[i]   = v_q[i-1];
            s_in[i]   = s_q[i-1];
            rev_in[i] = rev_q[i-1];
            tag_in[i] = tag_q[i-1];
        end
    end

    // Mux levels split evenly across stages; stage i applies levels [i*L/S, (i+1)*L/S).
    always_comb begin
        for (int i = 0; i < int'(STAGES); i++) begin
            v_sh[i] = v_in[i];
            for (int j = 0; j < int'(LVLS); j++) begin
                if ((j >= (i * int'(LVLS)) / int'(STAGES)) &&
                    (j <  ((i + 1) * int'(LVLS)) / int'(STAGES)) && s_in[i][j]) begin
                    v_sh[i] = v_sh[i] >> (1 << j);
                end
            end
        end
    end

    // A stage may load when any stage at or beyond it is empty, or the output drains.
    always_comb begin
        rdy = '0;
        bub = 1'b0;
        for (int i = 0; i < int'(STAGES); i++) begin
            bub = 1'b0;
            for (int j = i; j < int'(STAGES); j++) begin
                bub = bub | ~vld_q[j];
            end
            rdy[i] = out_ready | bub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            for (int i = 0; i < int'(STAGES); i++) begin
                tag_q[i] <= '0;
                v_q[i]   <= '0;
                s_q[i]   <= '0;
                rev_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (flush) begin
                    vld_q[i] <= 1'b0;
                end else if (rdy[i]) begin
                    vld_q[i] <= vld_in[i];
                end
                if (rdy[i] && vld_in[i]) begin
                    tag_q[i] <= tag_in[i];
                    if (i < int'(STAGES) - 1) begin
                        v_q[i]   <= v_sh[i];
                        s_q[i]   <= s_in[i];
                        rev_q[i] <= rev_in[i];
                    end else begin
                        data_q  <= rev_in[i] ? bitrev(v_sh[i][WIDTH:1]) : v_sh[i][WIDTH:1];
                        carry_q <= v_sh[i][0];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed self-checking bench for shifter_pipe (WIDTH=32, STAGES=2).
module tb_shifter_pipe;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned AMTW   = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned TAGW   = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMTW-1:0]  in_amt;
    logic [1:0]       in_code;
    logic             in_regmode;
    logic             in_cflag;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAGW-1:0]  out_tag;

    int tests = 0;
    int fails = 0;

    shifter_pipe #(
        .WIDTH(WIDTH), .AMTW(AMTW), .STAGES(STAGES), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_code(in_code), .in_regmode(in_regmode),
        .in_cflag(in_cflag), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] code, input logic rm, input logic [7:0] amt,
                          input logic [31:0] data, input logic cf, input logic [3:0] tag);
        in_code    = code;
        in_regmode = rm;
        in_amt     = amt;
        in_data    = data;
        in_cflag   = cf;
        in_tag     = tag;
    endtask

    // One isolated op: accept, check two-cycle latency and the result, then let it drain.
    task automatic do_op(input string name, input logic [1:0] code, input logic rm,
                         input logic [7:0] amt, input logic [31:0] data, input logic cf,
                         input logic [3:0] tag, input logic [31:0] exp_d, input logic exp_c);
        set_op(code, rm, amt, data, cf, tag);
        in_valid = 1'b1;
        #1;
        chk({name, "_inrdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk({name, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        chk({name, "_vld"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, out_data, exp_d);
        chk({name, "_carry"}, 32'(out_carry), 32'(exp_c));
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        tick();
    endtask

    int k;
    int got;
    int cnt;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(2'd0, 1'b0, 8'd0, 32'd0, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        do_op("lsl_imm1", 2'd0, 1'b0, 8'd1, 32'h8000_0001, 1'b0, 4'h5, 32'h0000_0002, 1'b1);
        do_op("lsr_imm0", 2'd1, 1'b0, 8'd0, 32'h8000_0003, 1'b0, 4'h6, 32'h0000_0000, 1'b1);
        do_op("asr_imm0", 2'd2, 1'b0, 8'd0, 32'h8000_0003, 1'b0, 4'h7, 32'hFFFF_FFFF, 1'b1);
        do_op("rrx",      2'd3, 1'b0, 8'd0, 32'h8000_0003, 1'b1, 4'h8, 32'hC000_0001, 1'b1);
        do_op("asr_imm4", 2'd2, 1'b0, 8'd4, 32'h8000_0000, 1'b0, 4'h1, 32'hF800_0000, 1'b0);
        do_op("ror_imm8", 2'd3, 1'b0, 8'd8, 32'h1234_5678, 1'b1, 4'h2, 32'h7812_3456, 1'b0);
        do_op("lsl_imm4", 2'd0, 1'b0, 8'd4, 32'hF000_0000, 1'b0, 4'h3, 32'h0000_0000, 1'b1);
        do_op("lsr_imm4", 2'd1, 1'b0, 8'd4, 32'h0000_000F, 1'b0, 4'h4, 32'h0000_0000, 1'b1);
        do_op("lsl_imm0", 2'd0, 1'b0, 8'd0, 32'h0000_1234, 1'b1, 4'h9, 32'h0000_1234, 1'b1);

`ifdef SHIFTER_REGMODE_EN
        do_op("reg_lsl32", 2'd0, 1'b1, 8'd32, 32'h0000_0001, 1'b0, 4'hA, 32'h0000_0000, 1'b1);
        do_op("reg_lsl33", 2'd0, 1'b1, 8'd33, 32'h0000_0001, 1'b1, 4'hB, 32'h0000_0000, 1'b0);
        do_op("reg_ror64", 2'd3, 1'b1, 8'd64, 32'h8000_0000, 1'b0, 4'hC, 32'h8000_0000, 1'b1);
        do_op("reg_amt0",  2'd1, 1'b1, 8'd0,  32'h0000_0001, 1'b1, 4'hD, 32'h0000_0001, 1'b1);
        do_op("reg_lsr32", 2'd1, 1'b1, 8'd32, 32'h8000_0000, 1'b0, 4'hE, 32'h0000_0000, 1'b1);
        do_op("reg_asr40", 2'd2, 1'b1, 8'd40, 32'h8000_0000, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1);
        do_op("reg_ror36", 2'd3, 1'b1, 8'd36, 32'h1234_5678, 1'b0, 4'h1, 32'h8123_4567, 1'b1);
`else
        do_op("rm_ign_lsl", 2'd0, 1'b1, 8'd32, 32'h0000_0001, 1'b0, 4'hA, 32'h0000_0001, 1'b0);
        do_op("rm_ign_ror", 2'd3, 1'b1, 8'd64, 32'h8000_0000, 1'b0, 4'hB, 32'h4000_0000, 1'b0);
`endif

        // Backpressure: 5 LSL#1 ops, consumer stalled for the first 4 cycles.
        k   = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            out_ready = (c >= 4);
            in_valid  = (k < 5);
            set_op(2'd0, 1'b0, 8'd1, 32'h10 + 32'(k), 1'b0, 4'(k));
            #1;
            if (c == 2 || c == 3) begin
                chk("bp_stall_vld", 32'(out_valid), 32'd1);
                chk("bp_stall_data", out_data, 32'h20);
                chk("bp_stall_tag", 32'(out_tag), 32'd0);
            end
            if (c == 3) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_accepts", 32'(k), 32'd2);
            end
            if (out_valid && out_ready) begin
                chk("bp_order_data", out_data, (32'h10 + 32'(got)) << 1);
                chk("bp_order_tag", 32'(out_tag), 32'(got));
                chk("bp_order_carry", 32'(out_carry), 32'd0);
                got++;
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_delivered", 32'(got), 32'd5);
        tick();

        // Flush with two ops in flight and a third offered in the flush cycle.
        set_op(2'd1, 1'b0, 8'd1, 32'h100, 1'b0, 4'h1);
        in_valid = 1'b1;
        tick();
        set_op(2'd1, 1'b0, 8'd1, 32'h200, 1'b0, 4'h2);
        tick();
        set_op(2'd1, 1'b0, 8'd1, 32'h300, 1'b0, 4'h3);
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        chk("fl_inflight", 32'(out_valid), 32'd1);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("fl_nothing_emerges", 32'(cnt), 32'd0);

        // Asynchronous reset in the middle of a stream.
        set_op(2'd0, 1'b0, 8'd1, 32'h8000_0001, 1'b0, 4'h9);
        in_valid = 1'b1;
        tick();
        set_op(2'd0, 1'b0, 8'd2, 32'h4000_0001, 1'b0, 4'hA);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_vld", 32'(out_valid), 32'd1);
        chk("ar_pre_data", out_data, 32'h0000_0002);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_data", out_data, 32'd0);
        chk("ar_out_carry", 32'(out_carry), 32'd0);
        chk("ar_out_tag", 32'(out_tag), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_vld_after", 32'(out_valid), 32'd0);
        do_op("ar_first", 2'd2, 1'b0, 8'd1, 32'h8000_0001, 1'b0, 4'h6, 32'hC000_0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter: the next-generation datapath shifter for the execute stage. Supports LSL/LSR/ASR/ROR with both immediate-shift and register-shift semantics, generates the shifter carry-out, and accepts a configurable operand width and pipeline depth. A valid/ready handshake on both sides lets it sit between operand fetch and the ALU under stalls and flushes.

## Interface
- WIDTH, 32: data width; power of two, ≥ 8.
- AMTW, 8: shift-amount width; ≥ log2(WIDTH)+1.
- STAGES, 2: pipeline register stages, ≥ 1.
- TAGW, 4: sideband tag width, carried unmodified alongside the data.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  operand valid.
- in_ready  out  1  shifter accepts an operand this cycle.
- in_data  in  WIDTH  value to shift.
- in_amt  in  AMTW  shift amount.
- in_code  in  2  0=LSL, 1=LSR, 2=ASR, 3=ROR.
- in_regmode  in  1  1 = register-shift semantics, 0 = immediate semantics.
- in_cflag  in  1  current C flag.
- in_tag  in  TAGW  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.
- out_tag  out  TAGW  tag belonging to out_data.

## Operation
- Immediate mode: n = in_amt[log2(WIDTH)-1:0].
  - LSL: n=0 → out=in, c=cflag. Otherwise out=in<<n, c=in[WIDTH-n].
  - LSR: n=0 encodes WIDTH → out=0, c=in[WIDTH-1]. Otherwise out=in>>n, c=in[n-1].
  - ASR: n=0 encodes WIDTH → out = WIDTH copies of in[WIDTH-1], c=in[WIDTH-1]. Otherwise arithmetic shift, c=in[n-1].
  - ROR: n=0 is RRX → out={cflag, in[WIDTH-1:1]}, c=in[0]. Otherwise rotate right by n, c=out[WIDTH-1].
- Register mode: n = full in_amt.
  - For every code, n=0 → out=in, c=cflag.
  - LSL: n<WIDTH behaves as a normal shift. n=WIDTH → out=0, c=in[0]. n>WIDTH → out=0, c=0.
  - LSR: n<WIDTH behaves as a normal shift. n=WIDTH → out=0, c=in[WIDTH-1]. n>WIDTH → out=0, c=0.
  - ASR: n≥WIDTH → out = sign fill, c=in[WIDTH-1].
  - ROR: k = n mod WIDTH. k=0 (with n≠0) → out=in, c=in[WIDTH-1]. Otherwise rotate by k, c=out[WIDTH-1].
- Each stage holds a valid bit plus its payload. The log2(WIDTH) mux levels are distributed across the STAGES stages; the final stage drives out_*.
- A stage loads when it is empty or when its contents move forward in the same cycle.
- in_ready = stage 1 is empty, or stage 1 advances this cycle. in_ready may combinationally depend on out_ready.
- A transfer occurs on valid && ready. out_* hold stable while out_valid && !out_ready.
- flush clears every valid bit next edge and wins over a simultaneous accept; the input offered that cycle is dropped.

## Timing
- Reset (async assert, sync release): all valid bits = 0, out_data = 0, out_carry = 0, out_tag = 0.
- After reset, in_ready = 1.
- Latency: exactly STAGES cycles from accept to out_valid when there are no stalls.
- Throughput: one result per cycle while out_ready = 1.
- Full pipeline with out_ready = 0 → in_ready = 0. When out_ready rises, an accept may occur in the same cycle the output drains.
- Results leave in acceptance order. There is no reordering and no loss except on flush.
- Reset asserted mid-operation discards all in-flight data immediately.

## Configuration
- SHIFTER_REGMODE_EN defined: register-shift semantics as specified above.
- SHIFTER_REGMODE_EN undefined: in_regmode is ignored and every operation uses immediate semantics. The register-mode compare and mod logic is not built.

## Test plan
- WIDTH=32, STAGES=2. Immediate LSL in=0x80000001, amt=1 → two cycles later out=0x00000002, c=1, tag preserved.
- Immediate, amt=0, in=0x80000003:
  - LSR → out=0, c=1.
  - ASR → out=0xFFFFFFFF, c=1.
  - ROR with cflag=1 → out=0xC0000001, c=1.
- Register mode, in=0x00000001:
  - LSL amt=32 → out=0, c=1.
  - LSL amt=33 → out=0, c=0.
  - ROR amt=64 on 0x80000000 → out=0x80000000, c=1.
  - amt=0 with cflag=1 → pass-through, c=1.
- Backpressure: stream 5 ops with out_ready held 0 for 4 cycles → in_ready falls after 2 accepts. All 5 results are delivered in order once out_ready=1, with out_* stable while stalled.
- flush with 2 in flight and in_valid=1 → next cycle out_valid=0 and nothing from that cycle emerges later.
- rst_n pulsed low mid-stream (asynchronously) → outputs zero immediately. After release, in_ready=1 and the first new op appears STAGES cycles after it is accepted.
